// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W = 6;
    localparam int unsigned DEF_INST_W = 32;
    localparam int unsigned DEF_CNT_W  = 16;

    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// One-entry valid/ready output buffer holding a fetched word and its address.
module fetch_buf #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned INST_W = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              load,
    input  logic              flush,
    input  logic              ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
);

    logic              valid_q, valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // Flush wins over load; data regs keep their last value when not loading.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            inst_d  = in_inst;
            pc_d    = in_pc;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid   = valid_q;
    assign inst    = inst_q;
    assign inst_pc = pc_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address, buffers fetched
// words toward decode and applies execute-stage redirects.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       INST_W   = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned       CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_a,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  fetch_cnt
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              can_load;
    logic              load;
    logic              transfer;

    assign can_load = !inst_valid || inst_ready;
    assign transfer = inst_valid && inst_ready;
    assign load     = (state_q == FETCH) && run && can_load && !redirect_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (run)  state_d = FETCH;
            FETCH:   if (!run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Redirect has priority; pc+1 wraps naturally at ADDR_W bits.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (load) begin
            pc_d = pc_q + 1'b1;
        end
    end

    // A transfer counts even when a redirect flushes the buffer in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (transfer && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    fetch_buf #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_buf (
        .clk     (clk),
        .clrn    (clrn),
        .load    (load),
        .flush   (redirect_valid),
        .ready   (inst_ready),
        .in_inst (rom_inst),
        .in_pc   (pc_q),
        .valid   (inst_valid),
        .inst    (inst),
        .inst_pc (inst_pc)
    );

    assign rom_a     = pc_q;
    assign busy      = (state_q == FETCH);
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl with a word k = 0x1000_0000+k ROM.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic        run;
    logic [5:0]  rom_a;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [5:0]  redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [5:0]  inst_pc;
    logic        inst_ready;
    logic        busy;
    logic [15:0] fetch_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rom_inst = 32'h1000_0000 + {26'd0, rom_a};

    inst_fetch_ctrl dut (
        .clk            (clk),
        .clrn           (clrn),
        .run            (run),
        .rom_a          (rom_a),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .busy           (busy),
        .fetch_cnt      (fetch_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full output snapshot: valid, pc of buffered word, counter, rom address.
    task automatic chk_out(input string tag, input logic v, input logic [5:0] ipc,
                           input logic [15:0] cnt, input logic [5:0] ra);
        chk({tag, ".valid"}, 64'(inst_valid), 64'(v));
        if (v) begin
            chk({tag, ".inst_pc"}, 64'(inst_pc), 64'(ipc));
            chk({tag, ".inst"}, 64'(inst), 64'(32'h1000_0000 + {26'd0, ipc}));
        end
        chk({tag, ".cnt"}, 64'(fetch_cnt), 64'(cnt));
        chk({tag, ".rom_a"}, 64'(rom_a), 64'(ra));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, 64'(inst_valid), 64'd0);
        chk({tag, ".inst"}, 64'(inst), 64'd0);
        chk({tag, ".inst_pc"}, 64'(inst_pc), 64'd0);
        chk({tag, ".cnt"}, 64'(fetch_cnt), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".rom_a"}, 64'(rom_a), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0; run = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        #12;
        chk_reset("reset");
        tick();
        clrn = 1'b1;
        tick();
        chk_reset("idle_after_reset");

        // Start streaming; inst_ready high before valid must not count anything.
        run = 1'b1; inst_ready = 1'b1;
        tick();
        chk("start.busy", 64'(busy), 64'd1);
        chk_out("start.edgeN", 1'b0, 6'd0, 16'd0, 6'd0);
        for (int k = 0; k <= 5; k++) begin
            tick();
            chk_out($sformatf("stream%0d", k), 1'b1, 6'(k), 16'(k), 6'(k + 1));
        end

        // Backpressure at inst_pc 5.
        inst_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("bp%0d", k), 1'b1, 6'd5, 16'd5, 6'd6);
        end
        inst_ready = 1'b1;
        tick();
        chk_out("bp_release", 1'b1, 6'd6, 16'd6, 6'd7);
        tick();
        chk_out("to7", 1'b1, 6'd7, 16'd7, 6'd8);

        // Redirect while holding pc 7 with decode stalled: flush, no count.
        inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 6'h0B;
        tick();
        chk_out("flush7", 1'b0, 6'd0, 16'd7, 6'h0B);
        redirect_valid = 1'b0; inst_ready = 1'b1;
        tick();
        chk_out("target0B", 1'b1, 6'h0B, 16'd7, 6'h0C);

        // Redirect concurrent with a transfer: the transfer still counts.
        redirect_valid = 1'b1; redirect_pc = 6'h03;
        tick();
        chk_out("redir_to3", 1'b0, 6'd0, 16'd8, 6'h03);
        redirect_valid = 1'b0;
        tick();
        chk_out("at3", 1'b1, 6'h03, 16'd8, 6'h04);
        redirect_valid = 1'b1; redirect_pc = 6'h20;
        tick();
        chk_out("xfer_and_redir", 1'b0, 6'd0, 16'd9, 6'h20);
        redirect_valid = 1'b0;
        tick();
        chk_out("target20", 1'b1, 6'h20, 16'd9, 6'h21);

        // Wrap-around through 3F -> 00.
        redirect_valid = 1'b1; redirect_pc = 6'h3E;
        tick();
        chk_out("redir_3E", 1'b0, 6'd0, 16'd10, 6'h3E);
        redirect_valid = 1'b0;
        tick();
        chk_out("wrap3E", 1'b1, 6'h3E, 16'd10, 6'h3F);
        tick();
        chk_out("wrap3F", 1'b1, 6'h3F, 16'd11, 6'h00);
        tick();
        chk_out("wrap00", 1'b1, 6'h00, 16'd12, 6'h01);
        tick();
        chk_out("wrap01", 1'b1, 6'h01, 16'd13, 6'h02);

        // Drop run with a valid word held: it stays until accepted, then no loads.
        run = 1'b0; inst_ready = 1'b0;
        tick();
        chk("stop.busy", 64'(busy), 64'd0);
        chk_out("stop_hold0", 1'b1, 6'h01, 16'd13, 6'h02);
        tick();
        chk_out("stop_hold1", 1'b1, 6'h01, 16'd13, 6'h02);
        inst_ready = 1'b1;
        tick();
        chk_out("stop_accept", 1'b0, 6'd0, 16'd14, 6'h02);
        tick();
        chk_out("stop_noload", 1'b0, 6'd0, 16'd14, 6'h02);

        // Redirect applies to pc in IDLE as well.
        redirect_valid = 1'b1; redirect_pc = 6'h10;
        tick();
        redirect_valid = 1'b0;
        chk_out("idle_redir", 1'b0, 6'd0, 16'd14, 6'h10);
        chk("idle_redir.busy", 64'(busy), 64'd0);

        // Restart, then assert reset mid-stream.
        run = 1'b1;
        tick();
        chk_out("restart", 1'b0, 6'd0, 16'd14, 6'h10);
        tick();
        chk_out("restart10", 1'b1, 6'h10, 16'd14, 6'h11);
        tick();
        chk_out("restart11", 1'b1, 6'h11, 16'd15, 6'h12);
        #2;
        clrn = 1'b0;
        #1;
        chk_reset("async_reset");
        tick();
        chk_reset("reset_held");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
